// File: rtl/apb_pkg.sv
// Shared APB types and constants for the completer and the AXI4-Lite-to-APB bridge.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/apb_mem_array.sv
// Word array with byte-lane writes and a registered read port; contents are not reset.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  localparam int IDX_W = $clog2(MEM_WORDS)
) (
  input  logic                  s_axi_clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [APB_STRB_W-1:0] wr_strb,
  input  logic [APB_DATA_W-1:0] wr_dat,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [APB_DATA_W-1:0] rd_dat
);

  logic [APB_DATA_W-1:0] mem_q [MEM_WORDS];
  logic [APB_DATA_W-1:0] rd_dat_q;

  always_ff @(posedge s_axi_clk) begin
    if (wr_en) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
    if (rd_en) rd_dat_q <= mem_q[rd_idx];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer fronting a byte-strobed SRAM window; pready at cycle 1+WAIT_STATES after setup,
// then one DONE turnaround cycle. Out-of-window or misaligned accesses complete with pslverr.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  s_axi_clk,
  input  logic                  s_axi_aresetn,
  input  logic                  apb_psel,
  input  logic                  apb_penable,
  input  logic                  apb_pwrite,
  input  logic [31:0]           apb_paddr,
  input  logic [APB_DATA_W-1:0] apb_pwdata,
  input  logic [APB_STRB_W-1:0] apb_pstrb,
  input  logic [2:0]            apb_pprot,
  output logic [APB_DATA_W-1:0] apb_prdata,
  output logic                  apb_pready,
  output logic                  apb_pslverr
);

  localparam int          IDX_W  = $clog2(MEM_WORDS);
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(MEM_WORDS) * 33'd4;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [APB_DATA_W-1:0] wdat_q, wdat_d;
  logic [APB_STRB_W-1:0] strb_q, strb_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic                  setup;
  logic                  setup_err;
  logic [32:0]           addr_ext;
  logic [31:0]           offset;
  logic                  wr_en, rd_en;
  logic [APB_DATA_W-1:0] rd_dat;
  logic                  unused_ok;

  assign setup     = apb_psel & ~apb_penable;
  assign addr_ext  = {1'b0, apb_paddr};
  assign offset    = apb_paddr - BASE_ADDR;
  // 33-bit compare so a window ending exactly at 2^32 does not wrap
  assign setup_err = (addr_ext < WIN_LO) | (addr_ext >= WIN_HI) | (|apb_paddr[1:0]);
  assign unused_ok = ^{apb_pprot, offset[31:IDX_W+2], offset[1:0]};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    err_d      = err_q;
    wdat_d     = wdat_q;
    strb_d     = strb_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d    = ACCESS;
          wait_cnt_d = 4'(WAIT_STATES);
          idx_d      = offset[IDX_W+1:2];
          write_d    = apb_pwrite;
          err_d      = setup_err;
          wdat_d     = apb_pwdata;
          strb_d     = apb_pstrb;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            rd_en     = ~apb_pwrite & ~setup_err;
          end
        end
      end
      ACCESS: begin
        if (pready_q) begin
          wr_en   = write_q & ~err_q;
          state_d = DONE;
        end else if (!apb_psel) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            rd_en     = ~write_q & ~err_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      wdat_q     <= '0;
      strb_q     <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      err_q      <= err_d;
      wdat_q     <= wdat_d;
      strb_q     <= strb_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
    end
  end

  apb_mem_array #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .s_axi_clk (s_axi_clk),
    .wr_en     (wr_en),
    .wr_idx    (idx_q),
    .wr_strb   (strb_q),
    .wr_dat    (wdat_q),
    .rd_en     (rd_en),
    .rd_idx    (idx_d),
    .rd_dat    (rd_dat)
  );

  // Array read register holds stale data between reads, so gate it to the successful-read cycle
  assign apb_prdata  = (pready_q & ~pslverr_q & ~write_q) ? rd_dat : '0;
  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;

endmodule
